pic_inta_sequencer: RTL and testbench

- CPU-facing end of the PIC interrupt path.
- Consumes the Priority_Resolver outputs (masked requests and the one-hot winner) and drives INT to the CPU.
- Runs the two-pulse INTA acknowledge protocol: issues the one-cycle INTA_1 strobe back to the resolver, places the 8-bit vector on the data bus during the second INTA, and holds the In-Service Register with EOI/AEOI clearing.

---
 rtl/pic_inta_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: CPU-facing end of the PIC interrupt path.
// Raises INT, sequences the two-pulse INTA handshake, drives the vector and owns the ISR.
//
// state | meaning
// IDLE  | nothing to request; an unsolicited INTA still starts a sequence
// REQ   | INT asserted, waiting for the first INTA pulse
// ACK1  | first INTA low, level latched, ISR bit set
// GAP   | INTA high between the two pulses
// ACK2  | second INTA low, vector driven on the data bus

module pic_inta_sequencer #(
  parameter int VEC_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       IRR_MASKED,
  input  logic [7:0]       ISR_IRR,
  input  logic             INTA_n,
  input  logic             AEOI,
  input  logic             EOI_cmd,
  input  logic             EOI_specific,
  input  logic [2:0]       EOI_level,
  input  logic [VEC_W-1:0] VECTOR_BASE,
  output logic             INT,
  output logic             INTA_1,
  output logic [7:0]       IRR_CLR,
  output logic [7:0]       ISR,
  output logic [VEC_W+2:0] D_OUT,
  output logic             D_OE
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             meta_q, sync_q, prev_q;
  logic             fall, rise;
  logic [7:0]       below;
  logic             pend;
  logic             ack_spurious;
  logic [2:0]       ack_lvl;
  logic [7:0]       ack_mask;
  logic [7:0]       isr_low;
  logic [7:0]       eoi_clr;
  logic [7:0]       aeoi_clr;
  logic             first_ack;
  logic [2:0]       lvl, lvl_nxt;
  logic             int_nxt;
  logic             inta_1_nxt;
  logic [7:0]       irr_clr_nxt;
  logic [7:0]       isr_nxt;
  logic [VEC_W+2:0] d_out_nxt;
  logic             d_oe_nxt;

  // INTA_n is asynchronous: meta_q absorbs metastability, sync_q/prev_q feed the edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= INTA_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall = prev_q & ~sync_q;
  assign rise = ~prev_q & sync_q;

  // Only requests strictly above the highest-priority in-service level may interrupt
  always_comb begin
    below = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      if (ISR[i]) below = (8'h01 << i) - 8'h01;
    end
    pend = |(IRR_MASKED & below);
  end

  always_comb begin
    ack_spurious = ~|ISR_IRR;
    ack_lvl      = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (ISR_IRR[i]) ack_lvl = 3'(i);
    end
    ack_mask = ack_spurious ? 8'h00 : (8'h01 << ack_lvl);
  end

  assign isr_low = ISR & (~ISR + 8'd1);

  always_comb begin
    eoi_clr = 8'h00;
    if (EOI_cmd) eoi_clr = EOI_specific ? (8'h01 << EOI_level) : isr_low;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      INT     <= 1'b0;
      INTA_1  <= 1'b0;
      IRR_CLR <= 8'h00;
      ISR     <= 8'h00;
      D_OUT   <= '0;
      D_OE    <= 1'b0;
      lvl     <= 3'd0;
    end else begin
      state   <= state_nxt;
      INT     <= int_nxt;
      INTA_1  <= inta_1_nxt;
      IRR_CLR <= irr_clr_nxt;
      ISR     <= isr_nxt;
      D_OUT   <= d_out_nxt;
      D_OE    <= d_oe_nxt;
      lvl     <= lvl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fall)      state_nxt = ACK1;
        else if (pend) state_nxt = REQ;
      end
      REQ: begin
        if (fall)       state_nxt = ACK1;
        else if (!pend) state_nxt = IDLE;
      end
      ACK1:    if (rise) state_nxt = GAP;
      GAP:     if (fall) state_nxt = ACK2;
      ACK2:    if (rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // EOI/AEOI clears are applied before the acknowledge set so a same-bit set survives
  always_comb begin
    first_ack   = ((state == IDLE) || (state == REQ)) && fall;
    int_nxt     = (state_nxt == REQ);
    inta_1_nxt  = first_ack;
    irr_clr_nxt = first_ack ? ack_mask : 8'h00;
    lvl_nxt     = first_ack ? ack_lvl : lvl;
    d_out_nxt   = D_OUT;
    d_oe_nxt    = D_OE;
    aeoi_clr    = 8'h00;
    if ((state == GAP) && fall) begin
      d_out_nxt = {VECTOR_BASE, lvl};
      d_oe_nxt  = 1'b1;
    end
    if ((state == ACK2) && rise) begin
      d_oe_nxt = 1'b0;
      if (AEOI) aeoi_clr = 8'h01 << lvl;
    end
    isr_nxt = (ISR & ~(eoi_clr | aeoi_clr)) | irr_clr_nxt;
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed protocol scenarios plus randomized traffic,
// every cycle compared against a protocol-level reference model.

module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irr_masked = 8'h00;
  logic [7:0] isr_irr = 8'h00;
  logic       inta_n = 1'b1;
  logic       aeoi = 1'b0;
  logic       eoi_cmd = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic [4:0] vector_base = 5'b01000;
  logic       irq;
  logic       inta1;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic [7:0] d_out;
  logic       d_oe;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.VEC_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .IRR_MASKED   (irr_masked),
    .ISR_IRR      (isr_irr),
    .INTA_n       (inta_n),
    .AEOI         (aeoi),
    .EOI_cmd      (eoi_cmd),
    .EOI_specific (eoi_specific),
    .EOI_level    (eoi_level),
    .VECTOR_BASE  (vector_base),
    .INT          (irq),
    .INTA_1       (inta1),
    .IRR_CLR      (irr_clr),
    .ISR          (isr),
    .D_OUT        (d_out),
    .D_OE         (d_oe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the handshake as a count of INTA falls within a sequence
  logic       m_int = 1'b0;
  logic       m_inta1 = 1'b0;
  logic [7:0] m_irrclr = 8'h00;
  logic [7:0] m_isr = 8'h00;
  logic [7:0] m_dout = 8'h00;
  logic       m_doe = 1'b0;
  logic [2:0] m_lvl = 3'd0;
  int         acks = 0;
  bit         low = 1'b0;
  bit         inta_q[$] = '{1'b1, 1'b1, 1'b1};
  bit         m_fall, m_rise;
  logic [7:0] m_clr;
  int         m_l;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit pend_of(input logic [7:0] irr, input logic [7:0] cur_isr);
    int top = lowest(cur_isr);
    if (top < 0) top = 8;
    for (int i = 0; i < top; i++) if (irr[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_int = 1'b0; m_inta1 = 1'b0; m_irrclr = 8'h00; m_isr = 8'h00;
      m_dout = 8'h00; m_doe = 1'b0; m_lvl = 3'd0; acks = 0; low = 1'b0;
      inta_q = '{1'b1, 1'b1, 1'b1};
    end else begin
      m_fall = inta_q[0] && !inta_q[1];
      m_rise = !inta_q[0] && inta_q[1];
      m_clr = 8'h00;
      m_inta1 = 1'b0;
      m_irrclr = 8'h00;
      if (eoi_cmd) begin
        if (eoi_specific) m_clr[eoi_level] = 1'b1;
        else begin
          m_l = lowest(m_isr);
          if (m_l >= 0) m_clr[m_l] = 1'b1;
        end
      end
      if (acks == 0) begin
        if (m_fall) begin
          m_l = lowest(isr_irr);
          m_lvl = (m_l < 0) ? 3'd7 : 3'(m_l);
          if (m_l >= 0) m_irrclr[m_l] = 1'b1;
          m_inta1 = 1'b1;
          m_int = 1'b0;
          acks = 1;
          low = 1'b1;
        end else begin
          m_int = pend_of(irr_masked, m_isr);
        end
      end else if (acks == 1) begin
        if (low && m_rise) low = 1'b0;
        else if (!low && m_fall) begin
          acks = 2;
          low = 1'b1;
          m_doe = 1'b1;
          m_dout = {vector_base, m_lvl};
        end
      end else if (m_rise) begin
        m_doe = 1'b0;
        if (aeoi) m_clr[m_lvl] = 1'b1;
        acks = 0;
        low = 1'b0;
      end
      m_isr = (m_isr & ~m_clr) | m_irrclr;
      inta_q.push_back(inta_n);
      void'(inta_q.pop_front());
    end
  end

  int         inta1_cnt = 0;
  logic [7:0] irrclr_acc = 8'h00;

  task automatic tick();
    @(negedge clk);
    chk("int", irq, m_int);
    chk("inta_1", inta1, m_inta1);
    chk("irr_clr", irr_clr, m_irrclr);
    chk("isr", isr, m_isr);
    chk("d_out", d_out, m_dout);
    chk("d_oe", d_oe, m_doe);
    inta1_cnt += int'(inta1);
    irrclr_acc |= irr_clr;
    eoi_cmd = 1'b0;
  endtask

  task automatic inta_pair(input int lo1, input int gap, input int lo2, input int hi,
                           input int eoi_at, output logic [7:0] dout_seen,
                           output logic [7:0] isr_mid);
    inta_n = 1'b0;
    for (int i = 0; i < lo1; i++) begin
      tick();
      if (i + 1 == eoi_at) eoi_cmd = 1'b1;
    end
    inta_n = 1'b1;
    repeat (gap) tick();
    isr_mid = isr;
    inta_n = 1'b0;
    repeat (lo2) tick();
    dout_seen = d_oe ? d_out : 8'h00;
    inta_n = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic eoi_pulse(input logic spec, input logic [2:0] level);
    eoi_specific = spec;
    eoi_level = level;
    eoi_cmd = 1'b1;
    tick();
  endtask

  logic [7:0] dv, mid;
  int         cnt0;

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_isr", isr, 8'h00);
    chk("rst_int", irq, 1'b0);

    // basic acknowledge of IR4
    irr_masked = 8'h10; isr_irr = 8'h10;
    tick();
    chk("basic_int_rise", irq, 1'b1);
    tick();
    inta_pair(6, 4, 6, 4, 0, dv, mid);
    irr_masked = 8'h00;
    chk("basic_isr_mid", mid, 8'h10);
    chk("basic_vec", dv, 8'h44);
    chk("basic_isr_end", isr, 8'h10);
    eoi_pulse(1'b1, 3'd4);
    chk("basic_eoi", isr, 8'h00);

    // auto-EOI
    aeoi = 1'b1;
    irr_masked = 8'h10; isr_irr = 8'h10;
    repeat (2) tick();
    inta_pair(6, 4, 6, 4, 0, dv, mid);
    irr_masked = 8'h00;
    chk("aeoi_isr_mid", mid, 8'h10);
    chk("aeoi_isr_end", isr, 8'h00);
    aeoi = 1'b0;
    repeat (2) tick();

    // nesting below IR3 in service
    irr_masked = 8'h08; isr_irr = 8'h08;
    repeat (2) tick();
    inta_pair(5, 3, 5, 3, 0, dv, mid);
    irr_masked = 8'h00;
    chk("nest_isr_base", isr, 8'h08);
    irr_masked = 8'h20;
    repeat (4) tick();
    chk("nest_blocked", irq, 1'b0);
    irr_masked = 8'h22;
    tick();
    chk("nest_int", irq, 1'b1);
    isr_irr = 8'h02;
    inta_pair(6, 4, 6, 4, 0, dv, mid);
    irr_masked = 8'h00;
    chk("nest_isr", isr, 8'h0A);
    chk("nest_vec", dv, 8'h41);

    // EOI variants
    eoi_pulse(1'b0, 3'd0);
    chk("eoi_nonspec", isr, 8'h08);
    eoi_pulse(1'b1, 3'd3);
    chk("eoi_spec3", isr, 8'h00);
    eoi_pulse(1'b1, 3'd6);
    chk("eoi_spec6_empty", isr, 8'h00);

    // EOI on the same edge as the ISR set of the same bit
    irr_masked = 8'h08; isr_irr = 8'h08;
    repeat (2) tick();
    inta_pair(5, 3, 5, 3, 0, dv, mid);
    irr_masked = 8'h00;
    eoi_specific = 1'b1; eoi_level = 3'd3;
    inta_pair(6, 4, 6, 4, 2, dv, mid);
    chk("eoi_same_cycle", mid, 8'h08);
    eoi_pulse(1'b1, 3'd3);

    // spurious acknowledge after the request withdrew
    irr_masked = 8'h01; isr_irr = 8'h00;
    repeat (2) tick();
    chk("spur_int", irq, 1'b1);
    irr_masked = 8'h00;
    repeat (2) tick();
    chk("spur_int_drop", irq, 1'b0);
    cnt0 = inta1_cnt;
    irrclr_acc = 8'h00;
    inta_pair(5, 3, 5, 4, 0, dv, mid);
    chk("spur_inta1_pulses", 32'(inta1_cnt - cnt0), 32'd1);
    chk("spur_irr_clr", irrclr_acc, 8'h00);
    chk("spur_isr", isr, 8'h00);
    chk("spur_vec", dv, 8'h47);

    // reset in the middle of the second pulse
    irr_masked = 8'h04; isr_irr = 8'h04;
    repeat (2) tick();
    inta_n = 1'b0; repeat (6) tick();
    inta_n = 1'b1; repeat (4) tick();
    inta_n = 1'b0; repeat (4) tick();
    chk("rst_pre_doe", d_oe, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_doe", d_oe, 1'b0);
    chk("rst_async_isr", isr, 8'h00);
    chk("rst_async_int", irq, 1'b0);
    chk("rst_async_dout", d_out, 8'h00);
    repeat (2) tick();
    inta_n = 1'b1;
    irr_masked = 8'h00;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rst_after_isr", isr, 8'h00);
    chk("rst_after_doe", d_oe, 1'b0);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      aeoi = 1'($urandom_range(0, 1));
      vector_base = 5'($urandom);
      irr_masked = 8'($urandom);
      if ($urandom_range(0, 3) == 0) irr_masked = 8'h00;
      case ($urandom_range(0, 9))
        8:       isr_irr = 8'h00;
        9:       isr_irr = 8'($urandom);
        default: isr_irr = irr_masked & (~irr_masked + 8'd1);
      endcase
      repeat ($urandom_range(1, 6)) begin
        tick();
        if ($urandom_range(0, 5) == 0) begin
          eoi_specific = 1'($urandom_range(0, 1));
          eoi_level = 3'($urandom);
          eoi_cmd = 1'b1;
        end
      end
      if (irq || $urandom_range(0, 3) == 0) begin
        inta_pair($urandom_range(4, 8), $urandom_range(3, 6), $urandom_range(4, 8),
                  $urandom_range(3, 6), $urandom_range(0, 5), dv, mid);
        irr_masked = irr_masked & ~isr_irr;
      end
    end
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
